// File: rtl/xbus_pkg.sv
// Shared types and constants for the two-master peripheral bus arbiter.
package xbus_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
  localparam logic [31:0] DEAD_WORD = 32'hDEAD_BEEF;
  localparam int          CNT_W     = 8;
endpackage

// File: rtl/bus_watchdog.sv
// Cycle counter for an owned bus cycle; flags expiry on the TIMEOUT-th busy cycle.
module bus_watchdog
  import xbus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] FIRST = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Loaded with 1 at grant so the first busy cycle already reads as count 1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = FIRST;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= FIRST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == LIMIT);
endmodule

// File: rtl/xbus_arb.sv
// Round-robin arbiter sharing one Wishbone classic slave bus between two masters,
// with a watchdog that completes unanswered cycles with a fixed error word.
module xbus_arb
  import xbus_pkg::*;
#(
  parameter int          TIMEOUT = 255,
  parameter logic [31:0] DEAD    = DEAD_WORD
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [31:0]      m0_adr,
  input  logic [31:0]      m0_dat,
  input  logic [3:0]       m0_sel,
  input  logic             m0_we,
  input  logic             m0_cyc,
  output logic [31:0]      m0_rdt,
  output logic             m0_ack,
  input  logic [31:0]      m1_adr,
  input  logic [31:0]      m1_dat,
  input  logic [3:0]       m1_sel,
  input  logic             m1_we,
  input  logic             m1_cyc,
  output logic [31:0]      m1_rdt,
  output logic             m1_ack,
  output logic [31:0]      s_adr,
  output logic [31:0]      s_dat,
  output logic [3:0]       s_sel,
  output logic             s_we,
  output logic             s_cyc,
  input  logic [31:0]      s_rdt,
  input  logic             s_ack,
  output logic             owner,
  output logic             timeout,
  output logic [CNT_W-1:0] err_count
);
  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             grant, expired, own_cyc, own_ack;
  logic [31:0]      own_rdt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (wb_clk),
    .rst     (wb_rst),
    .clr     (grant),
    .en      (state_q == BUSY),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    err_d   = err_q;
    grant   = 1'b0;
    s_cyc   = 1'b0;
    s_adr   = '0;
    s_dat   = '0;
    s_sel   = '0;
    s_we    = 1'b0;
    own_ack = 1'b0;
    own_rdt = '0;
    timeout = 1'b0;
    own_cyc = owner_q ? m1_cyc : m0_cyc;
    case (state_q)
      IDLE: begin
        if (m0_cyc || m1_cyc) begin
          grant   = 1'b1;
          owner_d = (m0_cyc && m1_cyc) ? ~owner_q : m1_cyc;
          state_d = BUSY;
        end
      end
      BUSY: begin
        s_cyc = own_cyc;
        s_adr = owner_q ? m1_adr : m0_adr;
        s_dat = owner_q ? m1_dat : m0_dat;
        s_sel = owner_q ? m1_sel : m0_sel;
        s_we  = owner_q ? m1_we  : m0_we;
        // A real slave ack beats a watchdog expiry landing on the same cycle.
        if (s_ack) begin
          own_ack = 1'b1;
          own_rdt = s_rdt;
          state_d = IDLE;
        end else if (!own_cyc) begin
          state_d = IDLE;
        end else if (expired) begin
          s_cyc   = 1'b0;
          own_ack = 1'b1;
          own_rdt = DEAD;
          timeout = 1'b1;
          err_d   = sat_inc(err_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A cycle cut short by reset never completes towards either master.
    if (wb_rst) begin
      s_cyc   = 1'b0;
      own_ack = 1'b0;
      own_rdt = '0;
      timeout = 1'b0;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  assign m0_ack    = own_ack & ~owner_q;
  assign m1_ack    = own_ack &  owner_q;
  assign m0_rdt    = owner_q ? 32'h0 : own_rdt;
  assign m1_rdt    = owner_q ? own_rdt : 32'h0;
  assign owner     = owner_q;
  assign err_count = err_q;
endmodule

// File: tb/tb_xbus_arb.sv
// Table-driven bench for xbus_arb with a scoreboard queue and hand-written
// sequences for counter saturation and round-robin fairness.
module tb_xbus_arb;
  localparam logic [31:0] A0 = 32'h4000_0000;
  localparam logic [31:0] A1 = 32'h5000_0010;
  localparam logic [31:0] D0 = 32'h0000_AAAA;
  localparam logic [31:0] D1 = 32'h1234_5678;
  localparam logic [31:0] DW = 32'hDEAD_BEEF;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m1_we, m1_cyc;
  logic [31:0] m0_rdt, m1_rdt;
  logic        m0_ack, m1_ack;
  logic [31:0] s_adr, s_dat, s_rdt;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_ack;
  logic        owner, timeout;
  logic [7:0]  err_count;

  xbus_arb #(.TIMEOUT(4), .DEAD(DW)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m0_adr(m0_adr), .m0_dat(m0_dat), .m0_sel(m0_sel), .m0_we(m0_we), .m0_cyc(m0_cyc),
    .m0_rdt(m0_rdt), .m0_ack(m0_ack),
    .m1_adr(m1_adr), .m1_dat(m1_dat), .m1_sel(m1_sel), .m1_we(m1_we), .m1_cyc(m1_cyc),
    .m1_rdt(m1_rdt), .m1_ack(m1_ack),
    .s_adr(s_adr), .s_dat(s_dat), .s_sel(s_sel), .s_we(s_we), .s_cyc(s_cyc),
    .s_rdt(s_rdt), .s_ack(s_ack),
    .owner(owner), .timeout(timeout), .err_count(err_count)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic        rst, c0, c1, ack;
    logic [31:0] rdt;
    logic        chk;
    logic        e_cyc, e_own, e_a0, e_a1, e_to, e_we;
    logic [31:0] e_r0, e_r1, e_adr, e_dat;
    logic [3:0]  e_sel;
    logic [7:0]  e_err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  vec_t e;
  logic exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add(input logic rst, c0, c1, ack, input logic [31:0] rdt,
                     input logic chk, busy, cyc, own, a0, a1,
                     input logic [31:0] r0, r1, input logic to, input logic [7:0] err);
    vec_t v;
    v.rst = rst; v.c0 = c0; v.c1 = c1; v.ack = ack; v.rdt = rdt; v.chk = chk;
    v.e_cyc = cyc; v.e_own = own; v.e_a0 = a0; v.e_a1 = a1; v.e_to = to;
    v.e_r0 = r0; v.e_r1 = r1; v.e_err = err;
    v.e_adr = busy ? (own ? A1 : A0) : 32'h0;
    v.e_dat = busy ? (own ? D1 : D0) : 32'h0;
    v.e_sel = busy ? (own ? 4'hF : 4'h3) : 4'h0;
    v.e_we  = busy & own;
    tbl.push_back(v);
  endtask

  task automatic run_timeout(output logic got, output logic to, output logic [31:0] rd);
    got = 1'b0; to = 1'b0; rd = '0;
    @(posedge wb_clk); #1;
    m0_cyc = 1'b1; s_ack = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge wb_clk);
      if (m0_ack) begin
        got = 1'b1; to = timeout; rd = m0_rdt;
      end
    end
    @(posedge wb_clk); #1;
    m0_cyc = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic        got, to;
    logic [31:0] rd, rv;
    int          budget;

    wb_rst = 1'b1; m0_cyc = 0; m1_cyc = 0; s_ack = 0; s_rdt = '0;
    m0_adr = A0; m0_dat = D0; m0_sel = 4'h3; m0_we = 1'b0;
    m1_adr = A1; m1_dat = D1; m1_sel = 4'hF; m1_we = 1'b1;
    repeat (2) @(posedge wb_clk);
    #1 wb_rst = 1'b0;
    @(negedge wb_clk);
    check("reset s_cyc", s_cyc, 0);
    check("reset owner", owner, 1);
    check("reset acks", {m0_ack, m1_ack}, 0);
    check("reset m0_rdt", m0_rdt, 0);
    check("reset m1_rdt", m1_rdt, 0);
    check("reset timeout", timeout, 0);
    check("reset err_count", err_count, 0);

    // rst c0 c1 ack rdt | chk busy cyc own a0 a1 r0 r1 to err
    add(0,1,0,0,0,     1,0,0,1,0,0,0,0,0,0);
    add(0,1,0,0,0,     1,1,1,0,0,0,0,0,0,0);
    add(0,1,0,1,'h5A,  1,1,1,0,1,0,'h5A,0,0,0);
    add(0,0,0,0,0,     1,0,0,0,0,0,0,0,0,0);
    add(0,0,0,1,'h77,  1,0,0,0,0,0,0,0,0,0);
    add(1,0,0,0,0,     1,0,0,0,0,0,0,0,0,0);
    add(0,1,1,0,0,     1,0,0,1,0,0,0,0,0,0);
    add(0,1,1,0,0,     1,1,1,0,0,0,0,0,0,0);
    add(0,1,1,1,'h11,  1,1,1,0,1,0,'h11,0,0,0);
    add(0,0,1,0,0,     1,0,0,0,0,0,0,0,0,0);
    add(0,0,1,0,0,     1,1,1,1,0,0,0,0,0,0);
    add(0,0,1,1,'h22,  1,1,1,1,0,1,0,'h22,0,0);
    add(0,0,0,0,0,     1,0,0,1,0,0,0,0,0,0);
    add(0,1,0,0,0,     1,0,0,1,0,0,0,0,0,0);
    add(0,1,0,0,0,     1,1,1,0,0,0,0,0,0,0);
    add(0,0,0,0,0,     1,1,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,     1,0,0,0,0,0,0,0,0,0);
    add(0,0,1,0,0,     1,0,0,0,0,0,0,0,0,0);
    add(0,0,1,0,0,     1,1,1,1,0,0,0,0,0,0);
    add(1,0,1,0,0,     0,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,     1,0,0,1,0,0,0,0,0,0);
    add(0,0,1,0,0,     1,0,0,1,0,0,0,0,0,0);
    for (int k = 0; k < 3; k++) add(0,0,1,0,0, 1,1,1,1,0,0,0,0,0,0);
    add(0,0,1,0,0,     1,1,0,1,0,1,0,DW,1,0);
    add(0,0,0,0,0,     1,0,0,1,0,0,0,0,0,1);
    add(0,1,0,0,0,     1,0,0,1,0,0,0,0,0,1);
    for (int k = 0; k < 3; k++) add(0,1,0,0,0, 1,1,1,0,0,0,0,0,0,1);
    add(0,1,0,1,'h44,  1,1,1,0,1,0,'h44,0,0,1);
    add(0,0,0,0,0,     1,0,0,0,0,0,0,0,0,1);

    foreach (tbl[i]) begin
      @(posedge wb_clk); #1;
      wb_rst = tbl[i].rst; m0_cyc = tbl[i].c0; m1_cyc = tbl[i].c1;
      s_ack = tbl[i].ack; s_rdt = tbl[i].rdt;
      sb.push_back(tbl[i]);
      @(negedge wb_clk);
      e = sb.pop_front();
      if (e.chk) begin
        check($sformatf("row%0d s_cyc", i), s_cyc, e.e_cyc);
        check($sformatf("row%0d owner", i), owner, e.e_own);
        check($sformatf("row%0d m0_ack", i), m0_ack, e.e_a0);
        check($sformatf("row%0d m1_ack", i), m1_ack, e.e_a1);
        check($sformatf("row%0d m0_rdt", i), m0_rdt, e.e_r0);
        check($sformatf("row%0d m1_rdt", i), m1_rdt, e.e_r1);
        check($sformatf("row%0d timeout", i), timeout, e.e_to);
        check($sformatf("row%0d err_count", i), err_count, e.e_err);
        check($sformatf("row%0d s_adr", i), s_adr, e.e_adr);
        check($sformatf("row%0d s_dat", i), s_dat, e.e_dat);
        check($sformatf("row%0d s_sel", i), s_sel, e.e_sel);
        check($sformatf("row%0d s_we", i), s_we, e.e_we);
      end
    end

    // err_count starts at 1 here; 256 more forced timeouts must pin it at 255.
    for (int i = 0; i < 256; i++) begin
      run_timeout(got, to, rd);
      if (!got) begin
        n_total++;
        $display("FAIL sat ack wait: no ack in iteration %0d, required ack", i);
        break;
      end
      if (i == 252) check("sat err before limit", err_count, 254);
      if (i == 255) begin
        check("sat last timeout", to, 1);
        check("sat last rdt", rd, DW);
      end
    end
    check("sat err_count", err_count, 255);

    @(posedge wb_clk); #1;
    wb_rst = 1'b1; m0_cyc = 0; m1_cyc = 0; s_ack = 0;
    @(posedge wb_clk); #1;
    wb_rst = 1'b0; m0_cyc = 1; m1_cyc = 1;
    check("fair reset owner", owner, 1);
    for (int k = 0; k < 8; k++) exp_q.push_back(k[0]);
    rv = 32'hC0DE_0000;
    budget = 0;
    while (exp_q.size() > 0 && budget < 40) begin
      budget++;
      @(posedge wb_clk); #1;
      s_rdt = rv;
      s_ack = s_cyc;
      @(negedge wb_clk);
      if (m0_ack || m1_ack) begin
        check("fair grant", m1_ack, exp_q.pop_front());
        check("fair rdt", m1_ack ? m1_rdt : m0_rdt, rv);
        check("fair idle rdt", m1_ack ? m0_rdt : m1_rdt, 0);
        check("fair single ack", m0_ack & m1_ack, 0);
        rv++;
      end
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL fairness wait: %0d grants missing, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/xbus_arb.md
# xbus_arb

Two-master arbiter that shares the peripheral data bus (GPIO, SPI, UART chip-select region) between the CPU data bus and a second bus master such as a DMA or debug engine. It grants ownership round-robin, holds the grant for a whole Wishbone classic cycle, and routes address, data and ack between the owner and the shared slave side. A watchdog terminates any cycle no slave acknowledges, returning a fixed error word so a stalled peripheral cannot hang either master.

## Interface

Parameters:
- TIMEOUT, 255: cycles in BUSY without s_ack before forced termination; legal range 2..255.
- DEAD, 32'hDEAD_BEEF: read data returned on a timed-out cycle.

Ports:
- wb_clk  in  1  clock; all logic on rising edge.
- wb_rst  in  1  synchronous, active-high reset.
- m0_adr / m1_adr  in  32  master address.
- m0_dat / m1_dat  in  32  master write data.
- m0_sel / m1_sel  in  4  byte selects.
- m0_we / m1_we  in  1  write enable.
- m0_cyc / m1_cyc  in  1  cycle request; held until the master sees its ack.
- m0_rdt / m1_rdt  out  32  read data; 0 when that master is not being acked.
- m0_ack / m1_ack  out  1  ack to that master.
- s_adr, s_dat, s_sel, s_we  out  32/32/4/1  shared-bus copies of the owner's signals; 0 when idle.
- s_cyc  out  1  shared-bus cycle.
- s_rdt  in  32  OR of slave read data.
- s_ack  in  1  OR of slave acks.
- owner  out  1  current/last grant (0 = m0, 1 = m1).
- timeout  out  1  one-cycle pulse on forced termination.
- err_count  out  8  saturating timeout count.

## Operation

- States: IDLE, BUSY.
- IDLE: s_cyc = 0 and all s_* outputs 0. If exactly one mN_cyc is high, grant it. If both are high, grant the master that is not `owner`. The grant registers `owner`, clears the watchdog and moves to BUSY.
- BUSY:
  - s_cyc = m[owner]_cyc; s_adr/s_dat/s_sel/s_we are routed combinationally from the owner.
  - s_ack high: m[owner]_ack = 1 and m[owner]_rdt = s_rdt in the same cycle; next state IDLE.
  - Owner drops cyc without an ack (abort): next state IDLE, no ack issued.
  - Watchdog reaches TIMEOUT with no s_ack:
    - s_cyc forced 0 that cycle.
    - m[owner]_ack = 1 and m[owner]_rdt = DEAD.
    - timeout pulses; err_count increments, saturating at 255.
    - Next state IDLE.
  - s_ack and watchdog expiry in the same cycle: s_ack wins. Normal ack, no timeout, no count.
- The non-owner always sees ack = 0 and rdt = 0. Its request waits and is never dropped.
- Fairness: with both masters requesting continuously, grants alternate m0, m1, m0, ...

## Timing

- Reset values: state IDLE, owner = 1 (so m0 wins the first tie), err_count 0, timeout 0, s_cyc 0, every ack 0, every rdt 0.
- Reset asserted mid-cycle: the next edge forces IDLE and no ack is issued.
- Grant latency: mN_cyc rising at edge k gives s_cyc high from edge k+1.
- Ack path from s_ack to mN_ack is combinational (zero cycles).
- After an ack the arbiter spends at least one cycle in IDLE. A re-request is granted one cycle later, so back-to-back cycles from one master are 1 idle cycle apart on s_cyc.
- Watchdog: counts cycles in BUSY starting at 1 on the first BUSY cycle. Expiry occurs on the cycle where the count equals TIMEOUT.
- The shared slave side must not ack while s_cyc = 0. Any s_ack seen in IDLE is ignored.

## Structure

- Package xbus_pkg: state encoding (IDLE, BUSY), the DEAD default, and the 8-bit count width.
- Sub-module bus_watchdog: holds the TIMEOUT counter, with clear and enable inputs and an `expired` output. The arbiter FSM and mux stay in xbus_arb.

## Test plan

- Single read: m0_cyc with adr 0x4000_0000; slave acks with rdt 0x5A on the 2nd BUSY cycle -> m0_ack for 1 cycle with m0_rdt = 0x5A; m1_ack = 0 throughout.
- Tie after reset: m0_cyc and m1_cyc rise together -> m0 served first; m1 granted the cycle after m0's ack plus 1 IDLE cycle; owner goes 0 then 1.
- Fairness: both masters request continuously with the slave acking in 1 cycle -> over 8 transactions the grants alternate 0,1,0,1,... and neither master starves.
- Timeout: m1 write to an unmapped address with TIMEOUT = 4 and no s_ack -> m1_ack with m1_rdt = 0xDEADBEEF on the 4th BUSY cycle, timeout pulse, err_count = 1, s_cyc low that cycle.
- Collision: s_ack arrives on exactly the TIMEOUT cycle -> normal ack with slave data, timeout stays 0, err_count unchanged. Then 256 forced timeouts -> err_count holds at 255.
- Abort and reset: owner drops cyc in BUSY -> IDLE next cycle with no ack. wb_rst asserted in BUSY -> s_cyc 0 and all acks 0 after the next edge, owner = 1.
